// File: rtl/load_register.sv
// W-bit load-enable storage register, built as one hold/load mux + D flip-flop cell per bit.
// Optional even-parity output enabled by defining LOAD_REGISTER_PARITY_EN.
module load_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] OUT,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD
`ifdef LOAD_REGISTER_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cell_d;
    logic cell_q;

    always_comb begin
      cell_d = LOAD ? IN[i] : cell_q;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        cell_q <= RESET_VALUE[i];
      end else begin
        cell_q <= cell_d;
      end
    end

    assign OUT[i] = cell_q;
  end

`ifdef LOAD_REGISTER_PARITY_EN
  // Parity is computed from the value being written, so it lands on the same edge as OUT.
  logic parity_d;
  logic parity_q;

  always_comb begin
    parity_d = LOAD ? ^IN : parity_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign PARITY = parity_q;
`endif

endmodule

// File: tb/tb_load_register.sv
// Directed self-checking bench for load_register: default 8-bit instance plus a
// 16-bit instance with a non-zero reset value.
module tb_load_register;

  logic        clk;
  logic        rst8, load8;
  logic [7:0]  in8, out8;
  logic        rst16, load16;
  logic [15:0] in16, out16;
`ifdef LOAD_REGISTER_PARITY_EN
  logic        par8, par16;
`endif

  int errors;
  int checks;

  load_register dut8 (
    .CLK   (clk),
    .RESET (rst8),
    .OUT   (out8),
    .IN    (in8),
    .LOAD  (load8)
`ifdef LOAD_REGISTER_PARITY_EN
    ,
    .PARITY(par8)
`endif
  );

  load_register #(
    .WIDTH      (16),
    .RESET_VALUE(16'h1234)
  ) dut16 (
    .CLK   (clk),
    .RESET (rst16),
    .OUT   (out16),
    .IN    (in16),
    .LOAD  (load16)
`ifdef LOAD_REGISTER_PARITY_EN
    ,
    .PARITY(par16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive8(input logic r, input logic l, input logic [7:0] d);
    @(negedge clk);
    rst8  = r;
    load8 = l;
    in8   = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive8(1'b1, 1'b1, 8'hFF);
    step();
    checks++;
    if (out8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h want %h", out8, 8'h00);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (par8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity: got %b want %b", par8, 1'b0);
    end
`endif
  endtask

  task automatic test_load_hold;
    logic [7:0] vin  [4] = '{8'b00001100, 8'b00001100, 8'b01001100, 8'b00000110};
    logic       vld  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] vexp [4] = '{8'h00, 8'b00001100, 8'b00001100, 8'b00000110};
    for (int i = 0; i < 4; i++) begin
      drive8(1'b0, vld[i], vin[i]);
      step();
      checks++;
      if (out8 !== vexp[i]) begin
        errors++;
        $display("FAIL load_hold[%0d]: got %b want %b", i, out8, vexp[i]);
      end
`ifdef LOAD_REGISTER_PARITY_EN
      checks++;
      if (par8 !== ^vexp[i]) begin
        errors++;
        $display("FAIL load_hold_parity[%0d]: got %b want %b", i, par8, ^vexp[i]);
      end
`endif
    end
    // With LOAD high, a mid-cycle IN change must not reach OUT before the edge.
    drive8(1'b0, 1'b1, 8'h5A);
    #2;
    checks++;
    if (out8 !== 8'b00000110) begin
      errors++;
      $display("FAIL no_comb_path: got %b want %b", out8, 8'b00000110);
    end
    load8 = 1'b0;
    step();
  endtask

  task automatic test_hold_glitch;
    logic [7:0] vin [3] = '{8'b11101100, 8'b10101101, 8'b10101101};
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 1'b0, vin[i]);
      #1 in8 = ~vin[i];
      #1 in8 = vin[i];
      step();
      #2 in8 = 8'h3C;
      #1 in8 = vin[i];
      checks++;
      if (out8 !== 8'b00000110) begin
        errors++;
        $display("FAIL hold_glitch[%0d]: got %b want %b", i, out8, 8'b00000110);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vin [2] = '{8'b01000011, 8'b11111111};
    logic       vpar [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive8(1'b0, 1'b1, vin[i]);
      step();
      checks++;
      if (out8 !== vin[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, out8, vin[i]);
      end
`ifdef LOAD_REGISTER_PARITY_EN
      checks++;
      if (par8 !== vpar[i]) begin
        errors++;
        $display("FAIL back_to_back_parity[%0d]: got %b want %b", i, par8, vpar[i]);
      end
`else
      if (vpar[i] === 1'bx) $display("unexpected X in parity table");
`endif
    end
  endtask

  task automatic test_reset_mid;
    drive8(1'b1, 1'b1, 8'hA5);
    step();
    checks++;
    if (out8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", out8, 8'h00);
    end
    drive8(1'b0, 1'b1, 8'hA5);
    step();
    checks++;
    if (out8 !== 8'hA5) begin
      errors++;
      $display("FAIL reset_mid_reload: got %h want %h", out8, 8'hA5);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (par8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_parity: got %b want %b", par8, 1'b0);
    end
`endif
  endtask

  task automatic test_param;
    @(negedge clk);
    rst16 = 1'b1; load16 = 1'b1; in16 = 16'hFFFF;
    step();
    checks++;
    if (out16 !== 16'h1234) begin
      errors++;
      $display("FAIL param_reset: got %h want %h", out16, 16'h1234);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (par16 !== 1'b1) begin
      errors++;
      $display("FAIL param_reset_parity: got %b want %b", par16, 1'b1);
    end
`endif
    @(negedge clk);
    rst16 = 1'b0; load16 = 1'b0; in16 = 16'hBEEF;
    step();
    checks++;
    if (out16 !== 16'h1234) begin
      errors++;
      $display("FAIL param_hold: got %h want %h", out16, 16'h1234);
    end
    @(negedge clk);
    load16 = 1'b1;
    step();
    checks++;
    if (out16 !== 16'hBEEF) begin
      errors++;
      $display("FAIL param_load: got %h want %h", out16, 16'hBEEF);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (par16 !== 1'b1) begin
      errors++;
      $display("FAIL param_load_parity: got %b want %b", par16, 1'b1);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst8 = 1'b0; load8 = 1'b0; in8 = '0;
    rst16 = 1'b0; load16 = 1'b0; in16 = '0;
    test_reset();
    test_load_hold();
    test_hold_glitch();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
